// File: rtl/buf_sdp_bank_ring.sv
// Banked update/execute buffer managed as a ring of NUM_BANKS banks.
// The update side fills the bank at wr_ptr and commits it; the execute side reads
// the bank at rd_ptr in narrow lanes and releases it. Ownership is exclusive, so
// the write bank and the read bank can never coincide.
module buf_sdp_bank_ring #(
    parameter int unsigned BUF_UPDT_ADDR_WIDTH = 8,
    parameter int unsigned BUF_UPDT_DATA_WIDTH = 32,
    parameter int unsigned BUF_EXEC_DATA_WIDTH = 8,
    parameter int unsigned NUM_BANKS           = 2,
    parameter int unsigned READ_LATENCY        = 1,
    localparam int unsigned RATIO               = BUF_UPDT_DATA_WIDTH / BUF_EXEC_DATA_WIDTH,
    localparam int unsigned LANE_BITS           = $clog2(RATIO),
    localparam int unsigned BUF_EXEC_ADDR_WIDTH = BUF_UPDT_ADDR_WIDTH + LANE_BITS,
    localparam int unsigned BANK_W              = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int unsigned CNT_W               = $clog2(NUM_BANKS + 1),
    localparam int unsigned BYTES               = BUF_UPDT_DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [BYTES-1:0]               buf_updt_wr_en,
    input  logic [BUF_UPDT_ADDR_WIDTH-1:0] buf_updt_addr,
    input  logic [BUF_UPDT_DATA_WIDTH-1:0] buf_updt_data,
    input  logic                           buf_updt_commit,
    output logic                           buf_updt_ready,
    output logic [BANK_W-1:0]              buf_updt_bank,
    input  logic                           buf_exec_rd_en,
    input  logic [BUF_EXEC_ADDR_WIDTH-1:0] buf_exec_addr,
    input  logic                           buf_exec_release,
    output logic                           buf_exec_valid,
    output logic [BANK_W-1:0]              buf_exec_bank,
    output logic [BUF_EXEC_DATA_WIDTH-1:0] buf_exec_data,
    output logic                           buf_exec_data_vld,
    output logic [CNT_W-1:0]               buf_fill_cnt,
    input  logic                           err_clr,
    output logic                           err_wr_drop,
    output logic                           err_rd_drop
);

    localparam int unsigned DEPTH  = 1 << BUF_UPDT_ADDR_WIDTH;
    localparam int unsigned MEM_AW = BANK_W + BUF_UPDT_ADDR_WIDTH;

    // Bank b occupies entries [b*DEPTH, b*DEPTH+DEPTH-1]; {bank, addr} is that index.
    logic [BUF_UPDT_DATA_WIDTH-1:0] mem [NUM_BANKS * DEPTH];

    logic [BANK_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [BANK_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              err_wr_d, err_wr_q;
    logic              err_rd_d, err_rd_q;

    logic [BUF_EXEC_DATA_WIDTH-1:0] data1_d, data1_q;
    logic                           vld1_d, vld1_q;

    logic                           updt_ready;
    logic                           exec_valid;
    logic                           commit_fire;
    logic                           release_fire;
    logic                           rd_fire;
    logic [MEM_AW-1:0]              wr_idx;
    logic [MEM_AW-1:0]              rd_idx;
    logic [BUF_UPDT_ADDR_WIDTH-1:0] rd_word_addr;
    logic [BUF_EXEC_ADDR_WIDTH-1:0] rd_lane;
    logic [BUF_UPDT_DATA_WIDTH-1:0] rd_word;
    logic [BUF_EXEC_DATA_WIDTH-1:0] rd_lane_data;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        if (b == BANK_W'(NUM_BANKS - 1)) begin
            return '0;
        end
        return b + 1'b1;
    endfunction

    assign updt_ready     = (cnt_q < CNT_W'(NUM_BANKS));
    assign exec_valid     = (cnt_q != '0);
    assign buf_updt_ready = updt_ready;
    assign buf_exec_valid = exec_valid;
    assign buf_fill_cnt   = cnt_q;
    assign buf_updt_bank  = wr_ptr_q;
    assign buf_exec_bank  = rd_ptr_q;
    assign err_wr_drop    = err_wr_q;
    assign err_rd_drop    = err_rd_q;

    // Ring pointers, occupancy and sticky error flags.
    always_comb begin
        commit_fire  = buf_updt_commit && updt_ready;
        release_fire = buf_exec_release && exec_valid;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        err_wr_d     = err_wr_q;
        err_rd_d     = err_rd_q;

        if (commit_fire) begin
            wr_ptr_d = next_bank(wr_ptr_q);
        end
        if (release_fire) begin
            rd_ptr_d = next_bank(rd_ptr_q);
        end
        case ({commit_fire, release_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // A new error in the same cycle as err_clr leaves the flag set.
        if (err_clr) begin
            err_wr_d = 1'b0;
            err_rd_d = 1'b0;
        end
        if (!updt_ready && ((buf_updt_wr_en != '0) || buf_updt_commit)) begin
            err_wr_d = 1'b1;
        end
        if (!exec_valid && (buf_exec_rd_en || buf_exec_release)) begin
            err_rd_d = 1'b1;
        end
    end

    // Read address decode, lane select and first pipeline stage next-state.
    always_comb begin
        rd_fire      = buf_exec_rd_en && exec_valid;
        wr_idx       = {wr_ptr_q, buf_updt_addr};
        rd_word_addr = BUF_UPDT_ADDR_WIDTH'(buf_exec_addr >> LANE_BITS);
        rd_lane      = buf_exec_addr & BUF_EXEC_ADDR_WIDTH'(RATIO - 1);
        rd_idx       = {rd_ptr_q, rd_word_addr};
        rd_word      = mem[rd_idx];
        rd_lane_data = BUF_EXEC_DATA_WIDTH'(rd_word >> (rd_lane * BUF_EXEC_DATA_WIDTH));
        data1_d      = data1_q;
        vld1_d       = rd_fire;
        if (rd_fire) begin
            data1_d = rd_lane_data;
        end
    end

    // Byte-enabled writes into the current write bank; storage is never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BYTES); i++) begin
            if (updt_ready && buf_updt_wr_en[i]) begin
                mem[wr_idx][i*8 +: 8] <= buf_updt_data[i*8 +: 8];
            end
        end
    end

    // Control state and first read stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_wr_q <= 1'b0;
            err_rd_q <= 1'b0;
            data1_q  <= '0;
            vld1_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_wr_q <= err_wr_d;
            err_rd_q <= err_rd_d;
            data1_q  <= data1_d;
            vld1_q   <= vld1_d;
        end
    end

    if (READ_LATENCY > 1) begin : g_out_reg
        logic [BUF_EXEC_DATA_WIDTH-1:0] data2_d, data2_q;
        logic                           vld2_d, vld2_q;

        // Extra output register; data holds between reads.
        always_comb begin
            data2_d = data2_q;
            vld2_d  = vld1_q;
            if (vld1_q) begin
                data2_d = data1_q;
            end
        end

        // Output register state.
        always_ff @(posedge clk) begin
            if (rst) begin
                data2_q <= '0;
                vld2_q  <= 1'b0;
            end else begin
                data2_q <= data2_d;
                vld2_q  <= vld2_d;
            end
        end

        assign buf_exec_data     = data2_q;
        assign buf_exec_data_vld = vld2_q;
    end else begin : g_no_out_reg
        assign buf_exec_data     = data1_q;
        assign buf_exec_data_vld = vld1_q;
    end

endmodule
